apbdma_backend: RTL

Transfer engine directly downstream of the APB DMA configuration register block. It consumes the configured start/rw/start_addr/num_bytes, runs word-sized APB master transfers, buffers read data in a read FIFO, and returns busy and FIFO fill level to the register block. Write data comes from a valid/ready stream.

---
 rtl/apbdma_backend.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/apbdma_backend.sv
// apbdma_backend: APB master transfer engine behind the DMA config registers.
// Moves num_bytes between APB memory and either a read FIFO (rw=0) or a
// valid/ready write stream (rw=1), one word-sized beat at a time.
// Build option: APBDMA_BACKEND_ERR_ABORT_EN -- when defined, an APB slave
// error ends the transfer after the failing beat; otherwise the error is
// only recorded in err_o and the remaining beats still run.
module apbdma_backend #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int FifoDepth = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   rw_i,
  input  logic [AddrWidth-1:0]   start_addr_i,
  input  logic [7:0]             num_bytes_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [7:0]             rfifo_numelements_o,
  input  logic [DataWidth-1:0]   wdata_i,
  input  logic                   wvalid_i,
  output logic                   wready_o,
  output logic [DataWidth-1:0]   rdata_o,
  output logic                   rvalid_o,
  input  logic                   rready_i,
  output logic [AddrWidth-1:0]   paddr_o,
  output logic                   psel_o,
  output logic                   penable_o,
  output logic                   pwrite_o,
  output logic [DataWidth-1:0]   pwdata_o,
  output logic [DataWidth/8-1:0] pstrb_o,
  input  logic [DataWidth-1:0]   prdata_i,
  input  logic                   pready_i,
  input  logic                   pslverr_i
);

  localparam int BB = DataWidth / 8;
  localparam int PW = $clog2(FifoDepth);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, SETUP, ACCESS} state_e;

  state_e                 state_reg, state_next;
  logic                   start_prev_reg;
  logic                   rw_reg;
  logic [AddrWidth-1:0]   addr_reg;
  logic [7:0]             remaining_reg;
  logic [DataWidth-1:0]   pwdata_reg;
  logic                   done_reg;
  logic                   err_reg;

  logic [DataWidth-1:0]   mem_reg [FifoDepth];
  logic [PW-1:0]          wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]          count_reg;

  logic                   start_ok;
  logic                   beat_done;
  logic [7:0]             remaining_dec;
  logic                   abort;
  logic                   end_xfer;
  logic                   fifo_full;
  logic                   push;
  logic                   pop;

  // Only a fresh rising edge seen while idle launches a transfer.
  assign start_ok      = (state_reg == IDLE) && start_i && !start_prev_reg;
  assign beat_done     = (state_reg == ACCESS) && pready_i;
  assign remaining_dec = remaining_reg - 8'(BB);
`ifdef APBDMA_BACKEND_ERR_ABORT_EN
  assign abort = pslverr_i;
`else
  assign abort = 1'b0;
`endif
  assign end_xfer  = beat_done && ((remaining_dec == 8'd0) || abort);
  // No beat is in flight while in WAIT, so the registered count alone
  // tells whether the next read beat has a slot reserved for it.
  assign fifo_full = (count_reg == CW'(FifoDepth));
  assign push      = beat_done && !rw_reg;
  assign pop       = rready_i && (count_reg != '0);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // Next-state logic and the write-stream handshake.
  always_comb begin
    state_next = state_reg;
    wready_o   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_ok && (num_bytes_i != 8'd0)) state_next = WAIT;
      end
      WAIT: begin
        if (rw_reg) begin
          if (wvalid_i) begin
            wready_o   = 1'b1;
            state_next = SETUP;
          end
        end else if (!fifo_full) begin
          state_next = SETUP;
        end
      end
      SETUP:   state_next = ACCESS;
      ACCESS: begin
        if (pready_i) state_next = end_xfer ? IDLE : WAIT;
      end
      default: state_next = IDLE;
    endcase
  end

  // Previous start level for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) start_prev_reg <= 1'b0;
    else         start_prev_reg <= start_i;
  end

  // Transfer context: latched on start, advanced once per completed beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rw_reg        <= 1'b0;
      addr_reg      <= '0;
      remaining_reg <= '0;
    end else if (start_ok) begin
      rw_reg        <= rw_i;
      addr_reg      <= start_addr_i;
      remaining_reg <= num_bytes_i;
    end else if (beat_done) begin
      addr_reg      <= addr_reg + AddrWidth'(BB);
      remaining_reg <= remaining_dec;
    end
  end

  // Write word captured on the stream handshake, held through SETUP/ACCESS.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       pwdata_reg <= '0;
    else if (wready_o) pwdata_reg <= wdata_i;
  end

  // One-cycle completion pulse, coincident with the return to IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) done_reg <= 1'b0;
    else         done_reg <= end_xfer || (start_ok && (num_bytes_i == 8'd0));
  end

  // Sticky slave-error flag, cleared when a new transfer is accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                     err_reg <= 1'b0;
    else if (start_ok)               err_reg <= 1'b0;
    else if (beat_done && pslverr_i) err_reg <= 1'b1;
  end

  // FIFO storage: plain array without reset so it maps onto RAM.
  always_ff @(posedge clk_i) begin
    if (push) mem_reg[wr_ptr_reg] <= prdata_i;
  end

  // FIFO pointers and occupancy; simultaneous push and pop cancel out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign busy_o              = (state_reg != IDLE);
  assign done_o              = done_reg;
  assign err_o               = err_reg;
  assign rfifo_numelements_o = 8'(count_reg);
  assign rvalid_o            = (count_reg != '0);
  // Head word is forced to zero when empty so no stale RAM content leaks out.
  assign rdata_o             = rvalid_o ? mem_reg[rd_ptr_reg] : '0;
  assign psel_o              = (state_reg == SETUP) || (state_reg == ACCESS);
  assign penable_o           = (state_reg == ACCESS);
  assign paddr_o             = addr_reg;
  assign pwrite_o            = rw_reg;
  assign pwdata_o            = pwdata_reg;
  assign pstrb_o             = '1;

endmodule
